// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution window address sequencer.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_IMG_W = 28;
    localparam int DEF_IMG_H = 28;
    localparam int DEF_K     = 3;
    localparam int STALL_W   = 16;

endpackage

// File: rtl/conv_seq_cnt.sv
// Wrap counter: counts 0..MAX on enable and returns to 0 after MAX.
// wrap_o flags the terminal count, so an enabled cycle with wrap_o high is the wrap.
module conv_seq_cnt #(
    parameter int W   = 10,
    parameter int MAX = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap_o = (cnt_q == MAX_V);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_window_seq.sv
// Generates input-pixel addresses for every KxK window of an IMG_H x IMG_W map.
// Optional stall counter output is enabled by defining CONV_SEQ_PERF_EN.
module conv_window_seq
    import conv_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int K      = DEF_K,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_signal,
    input  logic              ready,
    output logic              valid,
    output logic [ADDR_W-1:0] ifmap_addr,
    output logic              last_win,
    output logic              last_all,
    output logic              done,
    output logic              busy
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] K_LAST    = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] OROW_LAST = ADDR_W'(IMG_H - K);

    state_e state_q;
    state_e state_d;
    logic   start_q;
    logic   trigger;
    logic   accept;

    logic [ADDR_W-1:0] kc_cnt, kr_cnt, ocol_cnt, orow_cnt;
    logic              kc_wrap, kr_wrap, ocol_wrap, orow_wrap;
    logic              kr_en, ocol_en, orow_en;

    // Offsets kr*IMG_W and orow*IMG_W, stepped by adds instead of multiplies.
    logic [ADDR_W-1:0] krow_off_q, krow_off_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;

    assign trigger = start_signal & ~start_q;

    // valid/ready: a beat transfers on a rising edge where valid & ready; while
    // valid is high and ready is low, address and flags stay frozen.
    assign valid  = (state_q == RUN);
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign accept = valid & ready;

    assign kr_en   = accept & kc_wrap;
    assign ocol_en = kr_en & kr_wrap;
    assign orow_en = ocol_en & ocol_wrap;

    conv_seq_cnt #(.W(ADDR_W), .MAX(K - 1)) u_kc (
        .clk(clk), .rst(rst), .en_i(accept), .cnt_o(kc_cnt), .wrap_o(kc_wrap)
    );

    conv_seq_cnt #(.W(ADDR_W), .MAX(K - 1)) u_kr (
        .clk(clk), .rst(rst), .en_i(kr_en), .cnt_o(kr_cnt), .wrap_o(kr_wrap)
    );

    conv_seq_cnt #(.W(ADDR_W), .MAX(IMG_W - K)) u_ocol (
        .clk(clk), .rst(rst), .en_i(ocol_en), .cnt_o(ocol_cnt), .wrap_o(ocol_wrap)
    );

    conv_seq_cnt #(.W(ADDR_W), .MAX(IMG_H - K)) u_orow (
        .clk(clk), .rst(rst), .en_i(orow_en), .cnt_o(orow_cnt), .wrap_o(orow_wrap)
    );

    assign last_win   = valid & (kr_cnt == K_LAST) & kc_wrap;
    assign last_all   = last_win & ocol_wrap & (orow_cnt == OROW_LAST);
    assign ifmap_addr = valid ? (row_base_q + krow_off_q + ocol_cnt + kc_cnt) : '0;

    always_comb begin
        krow_off_d = krow_off_q;
        row_base_d = row_base_q;
        if (kr_en) begin
            krow_off_d = kr_wrap ? '0 : krow_off_q + ROW_STEP;
        end
        if (orow_en) begin
            row_base_d = orow_wrap ? '0 : row_base_q + ROW_STEP;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trigger) state_d = RUN;
            RUN:     if (accept && last_all) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            krow_off_q <= '0;
            row_base_q <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_signal;
            krow_off_q <= krow_off_d;
            row_base_q <= row_base_d;
        end
    end

`ifdef CONV_SEQ_PERF_EN
    logic [STALL_W-1:0] stall_q;
    logic [STALL_W-1:0] stall_d;

    // Cleared by the trigger that actually launches a run; saturates at all-ones.
    always_comb begin
        stall_d = stall_q;
        if (trigger && state_q == IDLE) begin
            stall_d = '0;
        end else if (valid && !ready && stall_q != '1) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv_window_seq.sv
// Directed bench for conv_window_seq on a 5x5 map with a 3x3 kernel;
// build with CONV_SEQ_PERF_EN defined to also check the stall counter.
module tb_conv_window_seq;

    localparam int IW    = 5;
    localparam int IH    = 5;
    localparam int KK    = 3;
    localparam int AW    = 10;
    localparam int BEATS = (IH - KK + 1) * (IW - KK + 1) * KK * KK;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_signal;
    logic          ready;
    logic          valid;
    logic [AW-1:0] ifmap_addr;
    logic          last_win;
    logic          last_all;
    logic          done;
    logic          busy;
`ifdef CONV_SEQ_PERF_EN
    logic [15:0]   stall_cnt;
`endif

    logic [AW+1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            beats_run = 0;
    int            done_cnt = 0;
    int            stalls_run = 0;
    logic          mon_en = 1'b0;
    logic          prev_last_acc = 1'b0;

    conv_window_seq #(
        .IMG_W(IW), .IMG_H(IH), .K(KK), .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_signal(start_signal),
        .ready(ready),
        .valid(valid),
        .ifmap_addr(ifmap_addr),
        .last_win(last_win),
        .last_all(last_all),
        .done(done),
        .busy(busy)
`ifdef CONV_SEQ_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference order: orow, ocol, kr, kc; address from the plain formula.
    task automatic push_run();
        for (int orow = 0; orow <= IH - KK; orow++)
            for (int ocol = 0; ocol <= IW - KK; ocol++)
                for (int kr = 0; kr < KK; kr++)
                    for (int kc = 0; kc < KK; kc++) begin
                        int   a;
                        logic lw, la;
                        a  = (orow + kr) * IW + (ocol + kc);
                        lw = (kr == KK - 1) && (kc == KK - 1);
                        la = lw && (orow == IH - KK) && (ocol == IW - KK);
                        exp_q.push_back({la, lw, AW'(a)});
                    end
    endtask

    task automatic begin_run();
        push_run();
        beats_run  = 0;
        stalls_run = 0;
        done_cnt   = 0;
        step();
        start_signal = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int budget, output logic [15:0] stall_at_done);
        logic seen;
        seen = 1'b0;
        stall_at_done = '0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
`ifdef CONV_SEQ_PERF_EN
                stall_at_done = stall_cnt;
`endif
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        @(negedge clk);
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_beats"}, beats_run, BEATS);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // Scoreboard: pop one expected beat per accepted transfer.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                done_cnt++;
                check("done_after_last", prev_last_acc, 1);
                check("valid_busy_in_done", {valid, busy}, 0);
            end
            if (valid && ready) begin
                beats_run++;
                check("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    logic [AW+1:0] e;
                    e = exp_q.pop_front();
                    check($sformatf("beat%0d", beats_run), {last_all, last_win, ifmap_addr}, e);
                end
            end
            if (valid && !ready) stalls_run++;
            prev_last_acc = valid & ready & last_all;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0]   stall_seen;
        logic [AW-1:0] held;

        rst = 1'b1;
        start_signal = 1'b0;
        ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("reset_flags", {valid, busy, done, last_win, last_all}, 0);
        check("reset_addr", ifmap_addr, 0);
        step();
        rst = 1'b0;
        step();
        mon_en = 1'b1;

        // Basic run with one cycle of start latency.
        begin_run();
        @(negedge clk);
        check("latency_no_valid_yet", valid, 0);
        @(negedge clk);
        check("first_beat_valid", {valid, busy}, 2'b11);
        check("first_beat_addr", ifmap_addr, 0);
        wait_done("runA", 200, stall_seen);
        end_checks("runA");
        start_signal = 1'b0;
        step();

        // Backpressure: 3-cycle stall on the 4th beat, then 4 more later.
        begin_run();
        step();
        start_signal = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (valid && ifmap_addr == AW'(5)) break;
            step();
        end
        check("stall_at_addr5", ifmap_addr, 5);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall1_hold_addr", ifmap_addr, 5);
            check("stall1_hold_flags", {valid, last_win, last_all}, 3'b100);
        end
        ready = 1'b1;
        for (int i = 0; i < 200 && beats_run < 20; i++) step();
        held = ifmap_addr;
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall2_hold_addr", ifmap_addr, held);
        end
        ready = 1'b1;
        wait_done("runB", 200, stall_seen);
        end_checks("runB");
`ifdef CONV_SEQ_PERF_EN
        check("perf_stall_cnt", stall_seen, 7);
`endif

        // Held start level: exactly one run.
        begin_run();
        repeat (500) step();
        end_checks("runC_held");
        start_signal = 1'b0;
        step();

        // Reset mid-run at beat 40, with start rising in the reset cycle.
        begin_run();
        step();
        start_signal = 1'b0;
        for (int i = 0; i < 200 && beats_run < 40; i++) step();
        rst = 1'b1;
        start_signal = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_valid_busy", {valid, busy, done}, 0);
        check("rst_mid_addr", ifmap_addr, 0);
        step();
        check("rst_wins_over_trigger", valid, 0);
        exp_q.delete();
        push_run();
        beats_run = 0;
        done_cnt  = 0;
        rst = 1'b0;
        wait_done("runD_restart", 200, stall_seen);
        end_checks("runD_restart");
        start_signal = 1'b0;
        step();

        // Trigger pulse during a run is ignored and not queued.
        begin_run();
        step();
        start_signal = 1'b0;
        for (int i = 0; i < 200 && beats_run < 10; i++) step();
        start_signal = 1'b1;
        step();
        start_signal = 1'b0;
        wait_done("runE", 200, stall_seen);
        end_checks("runE");
        repeat (10) step();
        check("no_queued_trigger", {valid, busy}, 0);

        // Random backpressure.
        begin_run();
        step();
        start_signal = 1'b0;
        for (int i = 0; i < 1000 && done_cnt == 0; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            step();
        end
        ready = 1'b1;
        @(negedge clk);
        end_checks("runF_random");
`ifdef CONV_SEQ_PERF_EN
        check("perf_random_stall", stall_cnt, stalls_run);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
